// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin scheduler that lends one shared interval counter to N_REQ
//   requesters. The winner gets the counter, which runs from 0 up to the
//   length latched at grant time. The owner then receives a one-cycle done
//   pulse and the round-robin pointer moves past it.
//
// Ports
//   clk    in  1             rising-edge clock
//   reset  in  1             synchronous, active-high reset
//   req    in  N_REQ         per-requester request level
//   len    in  N_REQ*WIDTH   packed terminal counts, requester i uses len[i*WIDTH +: WIDTH]
//   grant  out N_REQ         one-hot owner of the counter, zero when unowned
//   done   out N_REQ         one-cycle completion pulse to the owner
//   busy   out 1             high while a run is in progress
//   count  out WIDTH         current counter value
//   owner  out 3             binary index of the current or last winner
module counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   len,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic [2:0]               owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]   lim_q, lim_d;

  logic [7:0]         req_ext_s;
  logic [3:0]         scan_idx_s;
  logic               scan_hit_s;
  logic               win_found_s;
  logic [2:0]         win_idx_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic [WIDTH-1:0]   win_len_s;

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [2:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (3'(i) == idx);
    end
    return v;
  endfunction

  // Index following idx, wrapping at N_REQ.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Round-robin scan: first requester at or after ptr, wrapping, plus its length.
  always_comb begin
    req_ext_s   = 8'(req);
    scan_idx_s  = 4'd0;
    scan_hit_s  = 1'b0;
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s  = {1'b0, ptr_q} + 4'(k);
      scan_idx_s  = (scan_idx_s >= 4'(N_REQ)) ? scan_idx_s - 4'(N_REQ) : scan_idx_s;
      scan_hit_s  = ~win_found_s & req_ext_s[scan_idx_s[2:0]];
      win_idx_s   = scan_hit_s ? scan_idx_s[2:0] : win_idx_s;
      win_found_s = win_found_s | scan_hit_s;
    end
    win_onehot_s = onehot(win_idx_s);
    win_len_s    = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_len_s = win_len_s | (len[i*WIDTH +: WIDTH] & {WIDTH{win_onehot_s[i]}});
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = {N_REQ{1'b0}};
    busy_d  = busy_q;
    count_d = count_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    lim_d   = lim_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d = win_onehot_s;
          owner_d = win_idx_s;
          count_d = {WIDTH{1'b0}};
          busy_d  = 1'b1;
          lim_d   = win_len_s;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Abort outranks completion: a dropped request never earns a done.
        if (!req_ext_s[owner_q]) begin
          grant_d = {N_REQ{1'b0}};
          busy_d  = 1'b0;
          count_d = {WIDTH{1'b0}};
          ptr_d   = next_idx(owner_q);
          state_d = IDLE;
        end else if (count_q == lim_q) begin
          grant_d = {N_REQ{1'b0}};
          busy_d  = 1'b0;
          done_d  = onehot(owner_q);
          ptr_d   = next_idx(owner_q);
          state_d = DONE;
        end else begin
          count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        // Dead cycle: requests are not arbitrated here.
        count_d = {WIDTH{1'b0}};
        state_d = IDLE;
      end
      default: begin
        grant_d = {N_REQ{1'b0}};
        busy_d  = 1'b0;
        count_d = {WIDTH{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= {N_REQ{1'b0}};
      done_q  <= {N_REQ{1'b0}};
      busy_q  <= 1'b0;
      count_q <= {WIDTH{1'b0}};
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      lim_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lim_q   <= lim_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
//   Scoreboard bench for counter_arbiter (N_REQ=4, WIDTH=5). Stimulus pushes
//   the expected active cycles (any cycle with grant or done non-zero),
//   each stamped with its cycle number. A monitor pops and compares every
//   active cycle the DUT shows.
module tb_counter_arbiter;

  typedef struct packed {
    int         at;
    logic [3:0] grant;
    logic [3:0] done;
    logic [4:0] count;
    logic [2:0] owner;
    logic       busy;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [19:0] len = 20'd0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [4:0]  count;
  logic [2:0]  owner;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t mon_got;
  ev_t mon_exp;

  counter_arbiter #(.N_REQ(4), .WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count),
    .owner (owner)
  );

  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every active cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (grant != 4'd0 || done != 4'd0) begin
      mon_got.at    = cyc;
      mon_got.grant = grant;
      mon_got.done  = done;
      mon_got.count = count;
      mon_got.owner = owner;
      mon_got.busy  = busy;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got at=%0d grant=%b done=%b count=%0d owner=%0d busy=%b, required no activity",
                 mon_got.at, mon_got.grant, mon_got.done, mon_got.count, mon_got.owner, mon_got.busy);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL event: got at=%0d grant=%b done=%b count=%0d owner=%0d busy=%b, required at=%0d grant=%b done=%b count=%0d owner=%0d busy=%b",
                   mon_got.at, mon_got.grant, mon_got.done, mon_got.count, mon_got.owner, mon_got.busy,
                   mon_exp.at, mon_exp.grant, mon_exp.done, mon_exp.count, mon_exp.owner, mon_exp.busy);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_len(input int i, input int v);
    len[i*5 +: 5] = 5'(v);
  endtask

  // Expected grant cycles for a run starting at 'start', optionally followed by done.
  task automatic exp_run(input int start, input int w, input int lim, input bit with_done);
    ev_t e;
    for (int k = 0; k <= lim; k++) begin
      e.at = start + k; e.grant = 4'b0001 << w; e.done = 4'd0;
      e.count = 5'(k); e.owner = 3'(w); e.busy = 1'b1;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.at = start + lim + 1; e.grant = 4'd0; e.done = 4'b0001 << w;
      e.count = 5'(lim); e.owner = 3'(w); e.busy = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (grant !== 4'd0 || done !== 4'd0 || busy !== 1'b0 || count !== 5'd0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d owner=%0d, required all zero",
               name, grant, done, busy, count, owner);
    end
  endtask

  initial begin
    int s;
    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Single request: requester 2, len 3
    set_len(2, 3); req = 4'b0100; s = cyc + 1;
    exp_run(s, 2, 3, 1'b1);
    wait_to(s + 4); req = 4'd0; wait_to(s + 8);

    // Round-robin fairness from ptr=0
    reset = 1'b1; @(negedge clk);
    check_idle("reset_between");
    reset = 1'b0; @(negedge clk);
    for (int i = 0; i < 4; i++) set_len(i, 1);
    req = 4'b1111; s = cyc + 1;
    for (int r = 0; r < 5; r++) exp_run(s + 4*r, r % 4, 1, 1'b1);
    wait_to(s + 18); req = 4'd0; wait_to(s + 22);

    // Boundary lengths: 0 and 31
    set_len(1, 0); req = 4'b0010; s = cyc + 1;
    exp_run(s, 1, 0, 1'b1);
    wait_to(s + 1); req = 4'd0; wait_to(s + 4);
    set_len(3, 31); req = 4'b1000; s = cyc + 1;
    exp_run(s, 3, 31, 1'b1);
    wait_to(s + 32); req = 4'd0; wait_to(s + 36);

    // Abort: owner 1 drops at count 4, pending requester 3 follows
    set_len(1, 10); set_len(3, 2); req = 4'b1010; s = cyc + 1;
    exp_run(s, 1, 4, 1'b0);
    exp_run(s + 6, 3, 2, 1'b1);
    wait_to(s + 4); req = 4'b1000;
    wait_to(s + 9); req = 4'd0; wait_to(s + 13);

    // Reset mid-run: move ptr to 2 first, then reset at count 5
    set_len(1, 0); req = 4'b0010; s = cyc + 1;
    exp_run(s, 1, 0, 1'b1);
    wait_to(s + 1); req = 4'd0; wait_to(s + 4);
    set_len(2, 9); set_len(0, 1); req = 4'b0100; s = cyc + 1;
    exp_run(s, 2, 5, 1'b0);
    wait_to(s + 5); reset = 1'b1; req = 4'b1101;
    @(negedge clk);
    check_idle("reset_mid_run");
    reset = 1'b0;
    exp_run(s + 7, 0, 1, 1'b1);
    wait_to(s + 9); req = 4'd0; wait_to(s + 13);

    // Length change mid-run is ignored
    set_len(0, 6); req = 4'b0001; s = cyc + 1;
    exp_run(s, 0, 6, 1'b1);
    wait_to(s + 2); set_len(0, 2);
    wait_to(s + 7); req = 4'd0; wait_to(s + 11);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares a single interval counter among `N_REQ` requesters. Each requester asks for the counter with a requested interval length; the block grants one requester at a time, runs the counter from 0 up to that length, and then pulses the owner's `done`. It sits between the timing consumers (display/peripheral sequencers) and the shared counting resource, so that a single counter serves all channels.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 5: counter and length width in bits.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: reset, synchronous, active-high.
- `req`  in  N_REQ: per-requester request level. Bit i is held high until `done[i]` or until the requester wants to abort.
- `len`  in  N_REQ*WIDTH: packed terminal counts. Requester i uses `len[i*WIDTH +: WIDTH]`.
- `grant`  out  N_REQ: one-hot owner of the counter. All zeros when no requester owns it.
- `done`  out  N_REQ: one-cycle completion pulse to the owner.
- `busy`  out  1: high while the block is in state RUN.
- `count`  out  WIDTH: current counter value.
- `owner`  out  3: binary index of the current or last winner.

## Operation
- **States:** IDLE, RUN, DONE. All outputs are registered.
- **Reset (`reset`=1 at a clock edge):**
  - State goes to IDLE.
  - `grant`=0, `done`=0, `busy`=0, `count`=0, `owner`=0.
  - Round-robin pointer `ptr`=0.
  - Reset overrides any state, including mid-RUN. No `done` is issued for an interrupted run.
- **IDLE:**
  - If `req`=0, stay in IDLE.
  - Otherwise select the winner w: the first set bit of `req`, scanning from `ptr` upward and wrapping modulo N_REQ.
  - Set `grant`=1<<w, `owner`=w, `count`=0, `busy`=1.
  - Latch `lim`=len[w]. Later changes on `len` are ignored for this run.
  - Go to RUN.
- **RUN**, checked in priority order:
  1. If `req[owner]`=0 (abort): `grant`=0, `busy`=0, `count`=0, `ptr`=owner+1 mod N_REQ, go to IDLE. No `done` pulse.
  2. Else if `count`==`lim`: `grant`=0, `busy`=0, `done[owner]`=1, `ptr`=owner+1 mod N_REQ, go to DONE. `count` holds at `lim`.
  3. Else `count`=`count`+1.
- **DONE:** `done`=0, `count`=0, go to IDLE. Requests are not arbitrated in this cycle.
- **Arithmetic:**
  - `count` never exceeds `lim`, so no wrap occurs inside a run.
  - `lim`=2^WIDTH−1 is legal: the run covers all 2^WIDTH values.
  - `lim`=0 is legal: the run has one RUN cycle at `count`=0.
- **Requester behaviour:**
  - Non-owner requests arriving during RUN or DONE wait. They are evaluated in the next IDLE cycle.
  - A requester that keeps `req` high after its own `done` is eligible again, but ranks last because of the pointer advance.
  - `ptr` changes only on completion or abort.

## Timing
- Request → grant latency: `req[i]` seen high at edge E (state IDLE) gives `grant[i]`=1 and `count`=0 after E.
- Grant width: `grant` stays high for exactly `lim`+1 cycles, while `count` runs 0..`lim`.
- `done[i]`: high for exactly one cycle, the cycle immediately after the last grant cycle. `grant` is 0 during that cycle.
- Back-to-back requests: two cycles with `grant`=0 between the end of one owner's grant and the next grant (the DONE cycle and the IDLE cycle).
- Abort: `req[owner]` seen low at edge E drops `grant` after E. The next arbitration happens at the following edge.
- Simultaneous requests: resolved only by the pointer scan. With `ptr`=0, req=4'b1111 grants 0, 1, 2, 3, 0, … in order.

## Test plan
- **Single request:** reset, then req=4'b0100, len[2]=3. Required: grant=4'b0100 one cycle later; count shows 0,1,2,3 on four consecutive grant cycles; done=4'b0100 in the next cycle with grant=0; busy low from that cycle onward.
- **Round-robin fairness:** req=4'b1111, all len=1, held high. Required: grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles with a 2-cycle gap between grants. `done` pulses in the matching order.
- **Boundary lengths:** len=0 gives one grant cycle and then done. len=31 (WIDTH=5) gives 32 grant cycles, count reaches 31, and there is no wrap to 0 before done.
- **Abort:** owner 1 with len=10 drops req[1] at count=4. Required: grant=0 at the next cycle, no done[1] pulse, and a pending req[3] is granted after one IDLE cycle.
- **Reset mid-run:** assert reset at count=5. Required: all outputs 0 after the edge, no done pulse, and the next arbitration starts from requester 0.
- **Length change mid-run:** change len[owner] from 6 to 2 during RUN. Required: the run still ends at count=6.
